// File: rtl/purchase_ctrl_if.sv
// Purchase controller bus: buy requests, credit and dispenser/debit handshake.
// The master side is the controller; the slave side is the surrounding datapath.
interface purchase_ctrl_if #(
  parameter int CREDIT_W = 8
);
  logic [3:0]          buy_pulse;
  logic [CREDIT_W-1:0] credit;
  logic                restock;
  logic                dispense_ack;
  logic                dispense_req;
  logic [1:0]          dispense_sel;
  logic                debit_valid;
  logic [CREDIT_W-1:0] debit_amount;
  logic                deny;
  logic [1:0]          deny_code;
  logic                busy;
  logic [3:0]          stock_empty;

  modport master (
    input  buy_pulse, credit, restock, dispense_ack,
    output dispense_req, dispense_sel, debit_valid, debit_amount,
    output deny, deny_code, busy, stock_empty
  );

  modport slave (
    output buy_pulse, credit, restock, dispense_ack,
    input  dispense_req, dispense_sel, debit_valid, debit_amount,
    input  deny, deny_code, busy, stock_empty
  );
endinterface

// File: rtl/purchase_ctrl.sv
// Purchase sequencer: arbitration, credit/stock check, dispense handshake and debit.
// Define PURCHASE_RR_EN for round-robin grant; default build uses fixed lowest-index priority.
module purchase_ctrl #(
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int PRICE0     = 10,
  parameter int PRICE1     = 20,
  parameter int PRICE2     = 30,
  parameter int PRICE3     = 50,
  parameter int DISP_TO    = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  purchase_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CHECK    = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;
  localparam logic [1:0] S_DEBIT    = 2'd3;
  localparam int         TMR_W      = $clog2(DISP_TO + 1);

  logic [1:0]         state, state_nxt;
  logic [1:0]         sel, sel_nxt, gnt;
  logic [3:0]         pending, req, clr_mask;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [STOCK_W-1:0] stock     [4];
  logic [STOCK_W-1:0] stock_nxt [4];
  logic               deny_nxt, dec, deny_q;
  logic [1:0]         code_nxt, code_q;
  logic [3:0]         stock_empty_q;
`ifdef PURCHASE_RR_EN
  logic [1:0]         last_granted;
  logic [1:0]         idx;
`endif

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] i);
    case (i)
      2'd0:    price_of = CREDIT_W'(PRICE0);
      2'd1:    price_of = CREDIT_W'(PRICE1);
      2'd2:    price_of = CREDIT_W'(PRICE2);
      default: price_of = CREDIT_W'(PRICE3);
    endcase
  endfunction

  assign req = pending | bus.buy_pulse;

  // Grant: the first hit in search order wins, so scan backwards and let later writes override.
  always_comb begin
    gnt = 2'd0;
`ifdef PURCHASE_RR_EN
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = last_granted + 2'(k + 1);
      if (req[idx]) gnt = idx;
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) gnt = 2'(k);
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    timer_nxt = timer;
    clr_mask  = 4'b0000;
    deny_nxt  = 1'b0;
    code_nxt  = 2'b00;
    dec       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req != 4'b0000) begin
          sel_nxt   = gnt;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (stock[sel] == '0) begin
          deny_nxt  = 1'b1;
          code_nxt  = 2'b10;
          clr_mask  = 4'b0001 << sel;
          state_nxt = S_IDLE;
        end else if (bus.credit < price_of(sel)) begin
          deny_nxt  = 1'b1;
          code_nxt  = 2'b01;
          clr_mask  = 4'b0001 << sel;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = '0;
          state_nxt = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (bus.dispense_ack) begin
          clr_mask  = 4'b0001 << sel;
          state_nxt = S_DEBIT;
        end else if (timer == TMR_W'(DISP_TO - 1)) begin
          deny_nxt  = 1'b1;
          code_nxt  = 2'b11;
          clr_mask  = 4'b0001 << sel;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        dec       = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Restock wins over a same-cycle decrement.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stock_nxt[i] = stock[i];
      if (bus.restock)
        stock_nxt[i] = STOCK_W'(INIT_STOCK);
      else if (dec && (sel == 2'(i)))
        stock_nxt[i] = stock[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sel           <= 2'd0;
      pending       <= 4'b0000;
      timer         <= '0;
      deny_q        <= 1'b0;
      code_q        <= 2'b00;
      stock_empty_q <= {4{INIT_STOCK == 0}};
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(INIT_STOCK);
`ifdef PURCHASE_RR_EN
      last_granted  <= 2'd3;
`endif
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      pending <= (pending | bus.buy_pulse) & ~clr_mask;
      timer   <= timer_nxt;
      deny_q  <= deny_nxt;
      code_q  <= code_nxt;
      for (int i = 0; i < 4; i++) begin
        stock[i]         <= stock_nxt[i];
        stock_empty_q[i] <= (stock_nxt[i] == '0);
      end
`ifdef PURCHASE_RR_EN
      if (state == S_IDLE && req != 4'b0000) last_granted <= gnt;
`endif
    end
  end

  assign bus.dispense_req = (state == S_DISPENSE);
  assign bus.dispense_sel = sel;
  assign bus.debit_valid  = (state == S_DEBIT);
  assign bus.debit_amount = (state == S_DEBIT) ? price_of(sel) : '0;
  assign bus.deny         = deny_q;
  assign bus.deny_code    = code_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.stock_empty  = stock_empty_q;

endmodule

// File: tb/tb_purchase_ctrl.sv
// Directed bench for purchase_ctrl: success, credit/stock/timeout denials,
// restock, simultaneous requests and asynchronous reset mid-dispense.
module tb_purchase_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] prev_zero = 4'b0000;

  purchase_ctrl_if #(.CREDIT_W(8)) bus ();

  purchase_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A stock counter sitting at zero must never be seen at all-ones next.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (prev_zero[i]) chk("no_wrap", 32'(dut.stock[i] == 4'hF), 32'd0);
      prev_zero[i] = (dut.stock[i] == 4'h0);
    end
  end

  task automatic buy_ok(input logic [1:0] item, input logic [7:0] cr,
                        input int ack_delay, input logic [7:0] amount);
    bus.credit    = cr;
    bus.buy_pulse = 4'b0001 << item;
    tick;
    bus.buy_pulse = 4'b0000;
    chk("ok_check_busy", bus.busy, 1);
    chk("ok_check_noreq", bus.dispense_req, 0);
    tick;
    chk("ok_disp_req", bus.dispense_req, 1);
    chk("ok_disp_sel", bus.dispense_sel, item);
    repeat (ack_delay) tick;
    bus.dispense_ack = 1'b1;
    tick;
    bus.dispense_ack = 1'b0;
    chk("ok_debit_valid", bus.debit_valid, 1);
    chk("ok_debit_amount", bus.debit_amount, amount);
    chk("ok_req_low", bus.dispense_req, 0);
    tick;
    chk("ok_idle", bus.busy, 0);
    chk("ok_debit_clear", bus.debit_valid, 0);
    chk("ok_amount_zero", bus.debit_amount, 0);
  endtask

  task automatic buy_deny(input logic [1:0] item, input logic [7:0] cr, input logic [1:0] code);
    bus.credit    = cr;
    bus.buy_pulse = 4'b0001 << item;
    tick;
    bus.buy_pulse = 4'b0000;
    tick;
    chk("deny_pulse", bus.deny, 1);
    chk("deny_code", bus.deny_code, code);
    chk("deny_no_req", bus.dispense_req, 0);
    chk("deny_idle", bus.busy, 0);
    tick;
    chk("deny_clear", bus.deny, 0);
    chk("deny_code_clear", bus.deny_code, 0);
  endtask

  task automatic serve_pair(input logic [1:0] first, input logic [1:0] second,
                            input logic [7:0] amt1, input logic [7:0] amt2);
    bus.credit    = 8'd255;
    bus.buy_pulse = 4'b1010;
    tick;
    bus.buy_pulse = 4'b0000;
    chk("pair_sel1", bus.dispense_sel, first);
    tick;
    chk("pair_req1", bus.dispense_req, 1);
    bus.dispense_ack = 1'b1;
    tick;
    bus.dispense_ack = 1'b0;
    chk("pair_amt1", bus.debit_amount, amt1);
    tick;
    chk("pair_idle_gap", bus.busy, 0);
    tick;
    chk("pair_busy2", bus.busy, 1);
    chk("pair_sel2", bus.dispense_sel, second);
    tick;
    chk("pair_req2", bus.dispense_req, 1);
    bus.dispense_ack = 1'b1;
    tick;
    bus.dispense_ack = 1'b0;
    chk("pair_amt2", bus.debit_amount, amt2);
    tick;
    tick;
    chk("pair_done", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.buy_pulse    = 4'b0000;
    bus.credit       = 8'd0;
    bus.restock      = 1'b0;
    bus.dispense_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_req", bus.dispense_req, 0);
    chk("rst_deny", bus.deny, 0);
    chk("rst_debit", bus.debit_valid, 0);
    chk("rst_empty", bus.stock_empty, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick;

    // Single successful purchase of item 0
    buy_ok(2'd0, 8'd25, 2, 8'd10);
    chk("stock0_after", dut.stock[0], 4);

    // Insufficient credit for item 1
    buy_deny(2'd1, 8'd15, 2'b01);
    chk("stock1_kept", dut.stock[1], 5);

    // Drain item 3, then out-of-stock, then restock
    for (int n = 0; n < 5; n++) begin
      chk("empty3_before", bus.stock_empty[3], 0);
      buy_ok(2'd3, 8'd255, 0, 8'd50);
    end
    chk("empty3_set", bus.stock_empty, 4'b1000);
    buy_deny(2'd3, 8'd255, 2'b10);
    bus.restock = 1'b1;
    tick;
    bus.restock = 1'b0;
    chk("restock_empty", bus.stock_empty, 4'b0000);
    chk("restock_stock3", dut.stock[3], 5);

    // Dispense timeout on item 2
    bus.credit    = 8'd255;
    bus.buy_pulse = 4'b0100;
    tick;
    bus.buy_pulse = 4'b0000;
    tick;
    repeat (15) begin
      chk("to_no_debit", bus.debit_valid, 0);
      tick;
    end
    chk("to_req_last", bus.dispense_req, 1);
    tick;
    chk("to_deny", bus.deny, 1);
    chk("to_code", bus.deny_code, 2'b11);
    chk("to_req_low", bus.dispense_req, 0);
    chk("to_no_debit_end", bus.debit_valid, 0);
    chk("to_stock2", dut.stock[2], 5);
    tick;

    // Asynchronous reset during DISPENSE
    bus.credit    = 8'd255;
    bus.buy_pulse = 4'b0001;
    tick;
    bus.buy_pulse = 4'b0000;
    tick;
    chk("ar_in_dispense", bus.dispense_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_req", bus.dispense_req, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_debit", bus.debit_valid, 0);
    chk("ar_pending", dut.pending, 0);
    chk("ar_stock0", dut.stock[0], 5);
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    buy_ok(2'd0, 8'd25, 1, 8'd10);

    // Simultaneous requests for items 1 and 3, twice
    serve_pair(2'd1, 2'd3, 8'd20, 8'd50);
    serve_pair(2'd1, 2'd3, 8'd20, 8'd50);

    // Ack outside DISPENSE is ignored
    bus.dispense_ack = 1'b1;
    tick;
    tick;
    bus.dispense_ack = 1'b0;
    chk("stray_ack_debit", bus.debit_valid, 0);
    chk("stray_ack_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
